// File: rtl/jk_pkg.sv
// Shared constants for the JK bank sequencer.
//   JK_*  : per-cell {j,k} codes
//   OP_*  : command opcodes
//   state_t : controller states
package jk_pkg;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_CLEAR  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_UP   = 2'b10;
    localparam logic [1:0] OP_DOWN = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

endpackage

// File: rtl/jk_bank_sequencer_cell.sv
// Single JK flip-flop cell.
//   clk   : system clock
//   reset : synchronous active-high reset, q -> 0
//   jk    : {j,k} code applied at the next rising edge
//   q     : cell state
module jk_cell
    import jk_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] jk,
    output logic       q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 1'b0;
        end else begin
            case (jk)
                JK_CLEAR:  q <= 1'b0;
                JK_SET:    q <= 1'b1;
                JK_TOGGLE: q <= ~q;
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_bank_sequencer.sv
// Command-driven sequencer for a bank of JK cells, forming a loadable
// up/down counter.
//   clk, reset       : clock, synchronous active-high reset
//   cmd_valid/ready  : command handshake
//   cmd_op           : NOP / LOAD / UP / DOWN
//   cmd_data         : LOAD value
//   cmd_steps        : count cycles for UP/DOWN
//   jk_bus           : JK codes applied to the cells this cycle
//   q                : bank state
//   busy             : command executing
//   done             : one-cycle completion pulse
module jk_bank_sequencer
    import jk_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [WIDTH-1:0]   cmd_data,
    input  logic [CNT_W-1:0]   cmd_steps,
    output logic [2*WIDTH-1:0] jk_bus,
    output logic [WIDTH-1:0]   q,
    output logic               busy,
    output logic               done
);

    state_t            state, state_nxt;
    logic [1:0]        op_r;
    logic [WIDTH-1:0]  data_r;
    logic [CNT_W-1:0]  rem;
    logic              accept;
    logic              is_count_op;
    logic              zero_count;
    logic              last_step;

    assign cmd_ready   = (state == ST_IDLE) && !reset;
    assign busy        = (state == ST_EXEC);
    assign accept      = cmd_valid && cmd_ready;
    assign is_count_op = (cmd_op == OP_UP) || (cmd_op == OP_DOWN);
    // UP/DOWN with zero steps completes without ever entering EXEC.
    assign zero_count  = accept && is_count_op && (cmd_steps == '0);
    assign last_step   = (state == ST_EXEC) && (rem <= CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept && ((cmd_op == OP_LOAD) || (is_count_op && (cmd_steps != '0)))) begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (last_step) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_r   <= OP_NOP;
            data_r <= '0;
            rem    <= '0;
            done   <= 1'b0;
        end else begin
            done <= last_step || zero_count;
            if (accept) begin
                op_r   <= cmd_op;
                data_r <= cmd_data;
                if (cmd_op == OP_LOAD) begin
                    rem <= CNT_W'(1);
                end else if (is_count_op) begin
                    rem <= cmd_steps;
                end else begin
                    rem <= '0;
                end
            end else if (state == ST_EXEC) begin
                rem <= rem - CNT_W'(1);
            end
        end
    end

    // Toggle enables: cell i toggles when all lower bits are ones (UP)
    // or all zeros (DOWN); the running products start true for cell 0.
    always_comb begin
        logic all_ones;
        logic all_zeros;
        jk_bus    = '0;
        all_ones  = 1'b1;
        all_zeros = 1'b1;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (state == ST_EXEC) begin
                case (op_r)
                    OP_LOAD: jk_bus[2*i +: 2] = data_r[i] ? JK_SET : JK_CLEAR;
                    OP_UP:   jk_bus[2*i +: 2] = all_ones  ? JK_TOGGLE : JK_HOLD;
                    OP_DOWN: jk_bus[2*i +: 2] = all_zeros ? JK_TOGGLE : JK_HOLD;
                    default: jk_bus[2*i +: 2] = JK_HOLD;
                endcase
            end
            all_ones  = all_ones  & q[i];
            all_zeros = all_zeros & ~q[i];
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .jk    (jk_bus[2*g +: 2]),
            .q     (q[g])
        );
    end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
module tb_jk_bank_sequencer;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic [7:0] cmd_steps;
    logic [7:0] jk_bus;
    logic [3:0] q;
    logic       busy;
    logic       done;

    jk_bank_sequencer #(.WIDTH(4), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_steps (cmd_steps),
        .jk_bus    (jk_bus),
        .q         (q),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic       rst;
        logic       v;
        logic [1:0] op;
        logic [3:0] d;
        logic [7:0] s;
        logic [3:0] q;
        logic       busy;
        logic       done;
        logic       rdy;
        logic [7:0] jk;
    } vec_t;

    vec_t vecs[$];

    // Reference model: counter value plus number of execute cycles left.
    int m_q, m_left, m_op, m_data;
    bit m_done;

    function automatic void model_step(input logic rst, input logic v, input logic [1:0] op,
                                       input logic [3:0] d, input logic [7:0] s);
        bit nd;
        nd = 0;
        if (rst) begin
            m_q = 0; m_left = 0; m_done = 0;
            return;
        end
        if (m_left > 0) begin
            if (m_op == 1)      m_q = d_or(m_data);
            else if (m_op == 2) m_q = (m_q + 1) % 16;
            else                m_q = (m_q + 15) % 16;
            m_left--;
            if (m_left == 0) nd = 1;
        end else if (v) begin
            m_op = int'(op);
            m_data = int'(d);
            if (op == 2'd1) m_left = 1;
            else if (op != 2'd0) begin
                if (s == 0) nd = 1;
                else m_left = int'(s);
            end
        end
        m_done = nd;
    endfunction

    function automatic int d_or(input int x);
        return x % 16;
    endfunction

    function automatic logic [7:0] model_jk();
        logic [7:0] r;
        int diff;
        r = '0;
        if (m_left == 0) return r;
        if (m_op == 1) begin
            for (int i = 0; i < 4; i++) r[2*i +: 2] = ((m_data >> i) & 1) != 0 ? 2'b10 : 2'b01;
        end else begin
            diff = (m_op == 2) ? (m_q ^ ((m_q + 1) % 16)) : (m_q ^ ((m_q + 15) % 16));
            for (int i = 0; i < 4; i++) r[2*i +: 2] = ((diff >> i) & 1) != 0 ? 2'b11 : 2'b00;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic v, input logic [1:0] op,
                         input logic [3:0] d, input logic [7:0] s);
        reset = rst; cmd_valid = v; cmd_op = op; cmd_data = d; cmd_steps = s;
        #1;
    endtask

    task automatic advance(input logic rst, input logic v, input logic [1:0] op,
                           input logic [3:0] d, input logic [7:0] s);
        @(posedge clk);
        model_step(rst, v, op, d, s);
        @(negedge clk);
        cyc++;
    endtask

    function automatic void add(input logic rst, input logic v, input logic [1:0] op,
                                input logic [3:0] d, input logic [7:0] s, input logic [3:0] eq,
                                input logic eb, input logic ed, input logic er, input logic [7:0] ej);
        vec_t t;
        t.rst = rst; t.v = v; t.op = op; t.d = d; t.s = s;
        t.q = eq; t.busy = eb; t.done = ed; t.rdy = er; t.jk = ej;
        vecs.push_back(t);
    endfunction

    initial begin
        logic       r_rst, r_v;
        logic [1:0] r_op;
        logic [3:0] r_d;
        logic [7:0] r_s;

        //   rst v  op     d     s      q     busy done rdy jk
        add(1, 0, 2'd0, 4'h0, 8'd0,  4'h0, 0, 0, 0, 8'h00); // reset state
        add(0, 1, 2'd1, 4'hA, 8'd0,  4'h0, 0, 0, 1, 8'h00); // LOAD A
        add(0, 0, 2'd0, 4'h0, 8'd0,  4'h0, 1, 0, 0, 8'h99);
        add(0, 0, 2'd0, 4'h0, 8'd0,  4'hA, 0, 1, 1, 8'h00);
        add(0, 1, 2'd1, 4'hE, 8'd0,  4'hA, 0, 0, 1, 8'h00); // LOAD E
        add(0, 0, 2'd0, 4'h0, 8'd0,  4'hA, 1, 0, 0, 8'hA9);
        add(0, 1, 2'd2, 4'h0, 8'd3,  4'hE, 0, 1, 1, 8'h00); // UP 3 in done cycle
        add(0, 0, 2'd0, 4'h0, 8'd0,  4'hE, 1, 0, 0, 8'h03);
        add(0, 0, 2'd0, 4'h0, 8'd0,  4'hF, 1, 0, 0, 8'hFF);
        add(0, 0, 2'd0, 4'h0, 8'd0,  4'h0, 1, 0, 0, 8'h03);
        add(0, 1, 2'd3, 4'h0, 8'd2,  4'h1, 0, 1, 1, 8'h00); // DOWN 2
        add(0, 0, 2'd0, 4'h0, 8'd0,  4'h1, 1, 0, 0, 8'h03);
        add(0, 0, 2'd0, 4'h0, 8'd0,  4'h0, 1, 0, 0, 8'hFF);
        add(0, 1, 2'd1, 4'h5, 8'd0,  4'hF, 0, 1, 1, 8'h00); // LOAD 5
        add(0, 0, 2'd0, 4'h0, 8'd0,  4'hF, 1, 0, 0, 8'h66);
        add(0, 1, 2'd2, 4'h0, 8'd0,  4'h5, 0, 1, 1, 8'h00); // UP 0
        add(0, 0, 2'd0, 4'h0, 8'd0,  4'h5, 0, 1, 1, 8'h00);
        add(0, 0, 2'd0, 4'h0, 8'd0,  4'h5, 0, 0, 1, 8'h00);
        add(0, 1, 2'd1, 4'h0, 8'd0,  4'h5, 0, 0, 1, 8'h00); // LOAD 0
        add(0, 0, 2'd0, 4'h0, 8'd0,  4'h5, 1, 0, 0, 8'h55);
        add(0, 1, 2'd2, 4'h0, 8'd10, 4'h0, 0, 1, 1, 8'h00); // UP 10
        add(0, 0, 2'd0, 4'h0, 8'd0,  4'h0, 1, 0, 0, 8'h03);
        add(0, 0, 2'd0, 4'h0, 8'd0,  4'h1, 1, 0, 0, 8'h0F);
        add(0, 0, 2'd0, 4'h0, 8'd0,  4'h2, 1, 0, 0, 8'h03);
        add(0, 0, 2'd0, 4'h0, 8'd0,  4'h3, 1, 0, 0, 8'h3F);
        add(0, 0, 2'd0, 4'h0, 8'd0,  4'h4, 1, 0, 0, 8'h03);
        add(1, 0, 2'd0, 4'h0, 8'd0,  4'h5, 1, 0, 0, 8'h0F); // reset mid-EXEC
        add(0, 0, 2'd0, 4'h0, 8'd0,  4'h0, 0, 0, 1, 8'h00);
        add(0, 0, 2'd0, 4'h0, 8'd0,  4'h0, 0, 0, 1, 8'h00);
        add(0, 1, 2'd2, 4'h0, 8'd2,  4'h0, 0, 0, 1, 8'h00); // UP 2
        add(0, 1, 2'd1, 4'h3, 8'd0,  4'h0, 1, 0, 0, 8'h03); // LOAD 3 held
        add(0, 1, 2'd1, 4'h3, 8'd0,  4'h1, 1, 0, 0, 8'h0F);
        add(0, 1, 2'd1, 4'h3, 8'd0,  4'h2, 0, 1, 1, 8'h00);
        add(0, 0, 2'd2, 4'hC, 8'd9,  4'h2, 1, 0, 0, 8'h5A); // inputs ignored
        add(0, 0, 2'd0, 4'h0, 8'd0,  4'h3, 0, 1, 1, 8'h00);
        add(0, 1, 2'd0, 4'h9, 8'd5,  4'h3, 0, 0, 1, 8'h00); // NOP
        add(0, 0, 2'd0, 4'h0, 8'd0,  4'h3, 0, 0, 1, 8'h00);

        m_q = 0; m_left = 0; m_op = 0; m_data = 0; m_done = 0;
        drive(1, 0, 2'd0, 4'h0, 8'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].v, vecs[i].op, vecs[i].d, vecs[i].s);
            check("tbl_q",    32'(q),         32'(vecs[i].q));
            check("tbl_busy", 32'(busy),      32'(vecs[i].busy));
            check("tbl_done", 32'(done),      32'(vecs[i].done));
            check("tbl_rdy",  32'(cmd_ready), 32'(vecs[i].rdy));
            check("tbl_jk",   32'(jk_bus),    32'(vecs[i].jk));
            advance(vecs[i].rst, vecs[i].v, vecs[i].op, vecs[i].d, vecs[i].s);
        end

        for (int n = 0; n < 600; n++) begin
            r_rst = ($urandom_range(0, 49) == 0);
            r_v   = $urandom_range(0, 1) == 1;
            r_op  = 2'($urandom_range(0, 3));
            r_d   = 4'($urandom_range(0, 15));
            r_s   = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 4));
            drive(r_rst, r_v, r_op, r_d, r_s);
            check("rnd_q",    32'(q),         32'(m_q));
            check("rnd_busy", 32'(busy),      32'(m_left != 0));
            check("rnd_done", 32'(done),      32'(m_done));
            check("rnd_rdy",  32'(cmd_ready), 32'((m_left == 0) && !r_rst));
            check("rnd_jk",   32'(jk_bus),    32'(model_jk()));
            advance(r_rst, r_v, r_op, r_d, r_s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
